// File: rtl/trace_recorder.sv
// Capture-side trace buffer: samples a bus into a circular memory, freezes POST samples
// after a trigger, then returns the stored samples oldest-first on demand.
module trace_recorder #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16,
    parameter int POST  = 8
) (
    input  logic                     clk,
    input  logic                     clear_n,
    input  logic                     arm,
    input  logic                     sample_en,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     trig,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     rd_last,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] POST_LEN = (AW+1)'(POST);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PRE  = 2'b01;
    localparam logic [1:0] S_POST = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      rd_cnt;
    logic [AW:0]      post_cnt;
    logic             wr;
    logic             rd_go;
    logic [AW-1:0]    wp_inc;
    logic [AW:0]      cnt_inc;
    logic [AW-1:0]    entry_rp;

    always_comb begin
        wr       = sample_en && (state == S_PRE || state == S_POST);
        wp_inc   = wp + 1'b1;
        cnt_inc  = (count == FULL) ? count : count + 1'b1;
        // Oldest entry once the final write lands: slot 0 until the buffer has wrapped.
        entry_rp = (cnt_inc == FULL) ? wp_inc : '0;
        rd_go    = (state == S_DONE) && rd_en && !arm && (rd_cnt < count);
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state    <= S_IDLE;
            count    <= '0;
            wp       <= '0;
            rp       <= '0;
            rd_cnt   <= '0;
            post_cnt <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state <= S_PRE;
                        count <= '0;
                        wp    <= '0;
                    end
                end
                S_PRE: begin
                    if (wr) begin
                        wp    <= wp_inc;
                        count <= cnt_inc;
                        if (trig) begin
                            if (POST == 0) begin
                                state  <= S_DONE;
                                rp     <= entry_rp;
                                rd_cnt <= '0;
                            end else begin
                                state    <= S_POST;
                                post_cnt <= POST_LEN;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (wr) begin
                        wp    <= wp_inc;
                        count <= cnt_inc;
                        if (post_cnt == 1) begin
                            state  <= S_DONE;
                            rp     <= entry_rp;
                            rd_cnt <= '0;
                        end
                        post_cnt <= post_cnt - 1'b1;
                    end
                end
                default: begin
                    if (arm) begin
                        state <= S_PRE;
                        count <= '0;
                        wp    <= '0;
                    end else if (rd_go) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem[rp];
                        rd_last  <= (rd_cnt + 1'b1 == count);
                        rp       <= rp + 1'b1;
                        rd_cnt   <= rd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
